// File: rtl/trng_word_collector_pkg.sv
// Shared defaults and encodings for the ring-oscillator word collector.
package trng_word_collector_pkg;

  localparam int TRNG_WORD_W     = 32;
  localparam int TRNG_FIFO_DEPTH = 4;
  localparam int TRNG_REP_LIMIT  = 34;

  typedef enum logic {
    PAIR_FIRST  = 1'b0,
    PAIR_SECOND = 1'b1
  } pair_state_e;

endpackage

// File: rtl/trng_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on pop_data while not empty.
module trng_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == CW'(0));
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign pop_data  = mem_r[rd_ptr_r];

  // Storage array; a push on a full FIFO is legal only alongside a pop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (do_push_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers and occupancy; flush empties the FIFO in one edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/trng_word_collector.sv
// Von Neumann corrector, word packer and repetition-count health test in front of a word FIFO.
module trng_word_collector
  import trng_word_collector_pkg::*;
#(
  parameter int WORD_W     = TRNG_WORD_W,
  parameter int FIFO_DEPTH = TRNG_FIFO_DEPTH,
  parameter int REP_LIMIT  = TRNG_REP_LIMIT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              raw_bit,
  output logic [WORD_W-1:0] rand_data,
  output logic              rand_valid,
  input  logic              rand_ready,
  output logic              health_fail
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int RUN_W = $clog2(REP_LIMIT + 1);

  pair_state_e       state_r, state_n;
  logic              a_r, a_n;
  logic [WORD_W-1:0] word_r, word_n;
  logic [CNT_W-1:0]  bit_cnt_r, bit_cnt_n;
  logic              pend_valid_r, pend_valid_n;
  logic [WORD_W-1:0] pend_word_r, pend_word_n;
  logic [RUN_W-1:0]  run_r, run_next_s, run_inc_s;
  logic              prev_r;
  logic              health_fail_r;

  logic              trip_s;
  logic              active_s;
  logic              fifo_push_s;
  logic [WORD_W-1:0] push_data_s;
  logic [WORD_W-1:0] shifted_s;
  logic              fifo_pop_s;
  logic              push_ok_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              rand_valid_s;
  logic [WORD_W-1:0] fifo_head_s;

  // Repetition count for the current raw sample, saturating at the limit.
  always_comb begin
    run_inc_s = (run_r == RUN_W'(REP_LIMIT)) ? run_r : run_r + 1'b1;
    if (raw_bit == prev_r) begin
      run_next_s = run_inc_s;
    end else begin
      run_next_s = RUN_W'(1);
    end
  end

  assign trip_s       = enable & ~health_fail_r & (run_next_s == RUN_W'(REP_LIMIT));
  assign active_s     = enable & ~health_fail_r & ~trip_s;
  assign rand_valid_s = ~fifo_empty_s & ~health_fail_r;
  assign fifo_pop_s   = rand_valid_s & rand_ready;
  assign push_ok_s    = ~fifo_full_s | fifo_pop_s;
  assign shifted_s    = {word_r[WORD_W-2:0], a_r};

  // Pair FSM, packer and pending-word stall handling.
  always_comb begin
    state_n      = state_r;
    a_n          = a_r;
    word_n       = word_r;
    bit_cnt_n    = bit_cnt_r;
    pend_valid_n = pend_valid_r;
    pend_word_n  = pend_word_r;
    fifo_push_s  = 1'b0;
    push_data_s  = pend_word_r;
    if (!active_s) begin
      if (!enable || trip_s) begin
        state_n      = PAIR_FIRST;
        word_n       = '0;
        bit_cnt_n    = '0;
        pend_valid_n = 1'b0;
        pend_word_n  = '0;
      end else begin
        state_n = state_r;
      end
    end else if (pend_valid_r) begin
      // Stalled: raw samples are ignored until the pending word gets in.
      if (push_ok_s) begin
        fifo_push_s  = 1'b1;
        pend_valid_n = 1'b0;
      end else begin
        pend_valid_n = 1'b1;
      end
    end else begin
      case (state_r)
        PAIR_FIRST: begin
          a_n     = raw_bit;
          state_n = PAIR_SECOND;
        end
        PAIR_SECOND: begin
          state_n = PAIR_FIRST;
          if (raw_bit != a_r) begin
            if (bit_cnt_r == CNT_W'(WORD_W - 1)) begin
              word_n    = '0;
              bit_cnt_n = '0;
              if (push_ok_s) begin
                fifo_push_s = 1'b1;
                push_data_s = shifted_s;
              end else begin
                pend_valid_n = 1'b1;
                pend_word_n  = shifted_s;
              end
            end else begin
              word_n    = shifted_s;
              bit_cnt_n = bit_cnt_r + 1'b1;
            end
          end else begin
            word_n = word_r;
          end
        end
        default: state_n = PAIR_FIRST;
      endcase
    end
  end

  // Corrector and packer state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= PAIR_FIRST;
      a_r          <= 1'b0;
      word_r       <= '0;
      bit_cnt_r    <= '0;
      pend_valid_r <= 1'b0;
      pend_word_r  <= '0;
    end else begin
      state_r      <= state_n;
      a_r          <= a_n;
      word_r       <= word_n;
      bit_cnt_r    <= bit_cnt_n;
      pend_valid_r <= pend_valid_n;
      pend_word_r  <= pend_word_n;
    end
  end

  // Health test state; the alarm is sticky until reset_n.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_r         <= '0;
      prev_r        <= 1'b0;
      health_fail_r <= 1'b0;
    end else if (!enable) begin
      run_r         <= '0;
      prev_r        <= 1'b0;
      health_fail_r <= health_fail_r;
    end else if (!health_fail_r) begin
      run_r         <= run_next_s;
      prev_r        <= raw_bit;
      health_fail_r <= trip_s;
    end else begin
      run_r         <= run_r;
      prev_r        <= prev_r;
      health_fail_r <= 1'b1;
    end
  end

  trng_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (fifo_push_s),
    .push_data (push_data_s),
    .pop       (fifo_pop_s),
    .flush     (trip_s),
    .pop_data  (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign rand_valid  = rand_valid_s;
  assign rand_data   = rand_valid_s ? fifo_head_s : '0;
  assign health_fail = health_fail_r;

endmodule
